// File: rtl/mod_exp_pipe_ctrl_if.sv
// Request/result bundle for the modular exponentiator: request handshake with operands,
// result handshake with error flag, and a busy indicator.
interface mod_exp_pipe_ctrl_if #(
   parameter int unsigned W      = 64,
   parameter int unsigned E_BITS = 64
);
   logic              in_valid;
   logic              in_ready;
   logic [W-1:0]      m;
   logic [E_BITS-1:0] e;
   logic [W-1:0]      n;
   logic [W-1:0]      r2;
   logic [W-1:0]      out;
   logic              err;
   logic              out_valid;
   logic              out_ready;
   logic              busy;

   modport master (
      output in_valid, m, e, n, r2, out_ready,
      input  in_ready, out, err, out_valid, busy
   );

   modport slave (
      input  in_valid, m, e, n, r2, out_ready,
      output in_ready, out, err, out_valid, busy
   );
endinterface

// File: rtl/mod_exp_pipe_ctrl.sv
// Modular exponentiator out = m^e mod n using left-to-right square-and-multiply over a
// bit-serial radix-2 Montgomery multiplier; each Montgomery product takes W+2 cycles.
module mod_exp_pipe_ctrl #(
   parameter int unsigned W          = 64,
   parameter int unsigned E_BITS     = 64,
   parameter bit          CONST_TIME = 1'b1
) (
   input logic                clk,
   input logic                rst_n,
   mod_exp_pipe_ctrl_if.slave bus
);

   localparam int unsigned CW = $clog2(W + 2);
   localparam int unsigned KW = (E_BITS > 1) ? $clog2(E_BITS) : 1;

   typedef enum logic [2:0] {
      StIdle, StRmod, StMbar, StSq, StMul, StFrom, StDone
   } state_t;

   state_t            state_q;
   logic [W-1:0]      m_q, n_q, r2_q;
   logic [E_BITS-1:0] e_q;
   logic [W-1:0]      xbar_q, mbar_q;
   logic [W-1:0]      a_q, b_q;
   logic [W+1:0]      t_q;
   logic [CW-1:0]     cnt_q;
   logic [KW-1:0]     k_q;
   logic [W-1:0]      out_q;
   logic              err_q, out_valid_q, in_ready_q, busy_q;

   logic [W+1:0]      t_add, t_odd, t_step, t_sub;
   logic [W-1:0]      op_a, op_b, mm_res;
   logic              mm_last, mm_active, bad_req;
   logic [KW-1:0]     e_msb;

   // One Montgomery iteration and the final conditional subtract; t stays below 2n.
   always_comb begin
      t_add  = t_q + (a_q[0] ? {2'b00, b_q} : '0);
      t_odd  = t_add[0] ? t_add + {2'b00, n_q} : t_add;
      t_step = t_odd >> 1;
      t_sub  = (t_q >= {2'b00, n_q}) ? t_q - {2'b00, n_q} : t_q;
   end

   assign mm_res    = t_sub[W-1:0];
   assign mm_last   = (cnt_q == CW'(W + 1));
   assign mm_active = (state_q != StIdle) && (state_q != StDone);

   always_comb begin
      op_a = xbar_q;
      op_b = xbar_q;
      case (state_q)
         StRmod: begin
            op_a = r2_q;
            op_b = W'(1);
         end
         StMbar: begin
            op_a = m_q;
            op_b = r2_q;
         end
         StMul:   op_a = mbar_q;
         StFrom:  op_b = W'(1);
         default: ;
      endcase
   end

   assign bad_req = !bus.n[0] || (bus.n < W'(3)) || (bus.m >= bus.n);

   always_comb begin
      e_msb = '0;
      for (int unsigned i = 0; i < E_BITS; i++) begin
         if (bus.e[i]) e_msb = KW'(i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         m_q         <= '0;
         n_q         <= '0;
         r2_q        <= '0;
         e_q         <= '0;
         xbar_q      <= '0;
         mbar_q      <= '0;
         a_q         <= '0;
         b_q         <= '0;
         t_q         <= '0;
         cnt_q       <= '0;
         k_q         <= '0;
         out_q       <= '0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         // Multiplier: load on cnt 0, W iterations, result valid on the last count.
         if (mm_active) begin
            if (cnt_q == '0) begin
               a_q <= op_a;
               b_q <= op_b;
               t_q <= '0;
            end else if (!mm_last) begin
               t_q <= t_step;
               a_q <= a_q >> 1;
            end
            cnt_q <= mm_last ? '0 : cnt_q + 1'b1;
         end

         case (state_q)
            StIdle: begin
               if (bus.in_valid && in_ready_q) begin
                  m_q        <= bus.m;
                  e_q        <= bus.e;
                  n_q        <= bus.n;
                  r2_q       <= bus.r2;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  cnt_q      <= '0;
                  if (bad_req) begin
                     out_q       <= '0;
                     err_q       <= 1'b1;
                     out_valid_q <= 1'b1;
                     state_q     <= StDone;
                  end else begin
                     err_q   <= 1'b0;
                     k_q     <= CONST_TIME ? KW'(E_BITS - 1) : e_msb;
                     state_q <= StRmod;
                  end
               end
            end
            StRmod: begin
               if (mm_last) begin
                  xbar_q  <= mm_res;
                  state_q <= StMbar;
               end
            end
            StMbar: begin
               if (mm_last) begin
                  mbar_q  <= mm_res;
                  state_q <= (!CONST_TIME && (e_q == '0)) ? StFrom : StSq;
               end
            end
            StSq: begin
               if (mm_last) begin
                  xbar_q <= mm_res;
                  if (CONST_TIME || e_q[k_q]) begin
                     state_q <= StMul;
                  end else begin
                     // Variable-time mode drops the multiply on zero bits.
                     k_q     <= k_q - 1'b1;
                     state_q <= (k_q == '0) ? StFrom : StSq;
                  end
               end
            end
            StMul: begin
               if (mm_last) begin
                  if (e_q[k_q]) xbar_q <= mm_res;
                  k_q     <= k_q - 1'b1;
                  state_q <= (k_q == '0) ? StFrom : StSq;
               end
            end
            StFrom: begin
               if (mm_last) begin
                  out_q       <= mm_res;
                  out_valid_q <= 1'b1;
                  state_q     <= StDone;
               end
            end
            StDone: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out       = out_q;
   assign bus.err       = err_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mod_exp_pipe_ctrl.sv
// Drives a constant-time and a variable-time instance with identical requests and checks
// both against a plain-arithmetic modular exponentiation model.
module tb_mod_exp_pipe_ctrl;

   localparam int unsigned W      = 16;
   localparam int unsigned E_BITS = 16;
   localparam int          CT_LAT = (3 + 2 * E_BITS) * (W + 2) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [W-1:0]  req_m = '0, req_n = '0, req_r2 = '0;
   logic [E_BITS-1:0] req_e = '0;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   mod_exp_pipe_ctrl_if #(.W(W), .E_BITS(E_BITS)) if_ct ();
   mod_exp_pipe_ctrl_if #(.W(W), .E_BITS(E_BITS)) if_nc ();

   assign if_ct.in_valid  = in_valid;
   assign if_ct.m         = req_m;
   assign if_ct.e         = req_e;
   assign if_ct.n         = req_n;
   assign if_ct.r2        = req_r2;
   assign if_ct.out_ready = out_ready;
   assign if_nc.in_valid  = in_valid;
   assign if_nc.m         = req_m;
   assign if_nc.e         = req_e;
   assign if_nc.n         = req_n;
   assign if_nc.r2        = req_r2;
   assign if_nc.out_ready = out_ready;

   mod_exp_pipe_ctrl #(.W(W), .E_BITS(E_BITS), .CONST_TIME(1'b1)) u_dut_ct (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_ct)
   );

   mod_exp_pipe_ctrl #(.W(W), .E_BITS(E_BITS), .CONST_TIME(1'b0)) u_dut_nc (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_nc)
   );

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   function automatic longint unsigned ref_exp(longint unsigned b, longint unsigned x,
                                               longint unsigned md);
      longint unsigned r = 1;
      b = b % md;
      while (x != 0) begin
         if (x[0]) r = (r * b) % md;
         b = (b * b) % md;
         x = x >> 1;
      end
      return r % md;
   endfunction

   function automatic logic [W-1:0] ref_r2(longint unsigned md);
      longint unsigned rr = (64'd1 << (2 * W)) % md;
      return rr[W-1:0];
   endfunction

   // Issues one request to both instances and checks result and latency.
   task automatic run_req(input string tag, input logic [W-1:0] rm, input logic [E_BITS-1:0] re,
                          input logic [W-1:0] rn, input logic [W-1:0] rr2);
      longint unsigned exp_out;
      logic exp_err;
      int lat_ct, lat_nc, cyc;
      exp_err = !rn[0] || (rn < 3) || (rm >= rn);
      exp_out = exp_err ? 0 : ref_exp(rm, re, rn);
      check({tag, "_idle_ready"}, longint'(if_ct.in_ready & if_nc.in_ready), 1);
      in_valid = 1'b1;
      req_m = rm; req_e = re; req_n = rn; req_r2 = rr2;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat_ct = 0; lat_nc = 0; cyc = 1;
      while ((lat_ct == 0 || lat_nc == 0) && cyc <= 2000) begin
         if (lat_ct == 0 && if_ct.out_valid) lat_ct = cyc;
         if (lat_nc == 0 && if_nc.out_valid) lat_nc = cyc;
         if (lat_ct == 0 || lat_nc == 0) begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      check({tag, "_ct_latency"}, lat_ct, exp_err ? 1 : CT_LAT);
      if (exp_err) check({tag, "_nc_latency"}, lat_nc, 1);
      else check({tag, "_nc_latency_bound"}, longint'(lat_nc > 0 && lat_nc <= CT_LAT), 1);
      check({tag, "_ct_out"}, if_ct.out, exp_out);
      check({tag, "_ct_err"}, if_ct.err, exp_err);
      check({tag, "_nc_out"}, if_nc.out, exp_out);
      check({tag, "_nc_err"}, if_nc.err, exp_err);
   endtask

   task automatic release_result(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_back_idle"}, longint'({if_ct.busy, if_nc.busy, if_ct.in_ready,
                                            if_nc.out_valid}), 4'b0010);
   endtask

   initial begin
      logic [W-1:0] rn, rm;
      logic [E_BITS-1:0] re;

      repeat (3) @(posedge clk);
      #1;
      check("reset_in_ready", if_ct.in_ready, 1);
      check("reset_busy", if_ct.busy, 0);
      check("reset_out_valid", if_ct.out_valid, 0);
      check("reset_out_err", longint'({if_ct.out, if_ct.err}), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_req("t1", 16'd5, 16'd3, 16'd23, 16'd12);
      check("t1_out_const", if_ct.out, 10);
      release_result("t1");

      run_req("t2a", 16'd2, 16'd10, 16'd65521, 16'd225);
      check("t2a_out_const", if_ct.out, 1024);
      release_result("t2a");
      run_req("t2b", 16'd7, 16'd65520, 16'd65521, 16'd225);
      check("t2b_out_const", if_nc.out, 1);
      release_result("t2b");

      run_req("t3", 16'd5, 16'd0, 16'd23, 16'd12);
      release_result("t3");

      run_req("t4a", 16'd5, 16'd3, 16'd24, 16'd0);
      release_result("t4a");
      run_req("t4b", 16'd30, 16'd3, 16'd23, 16'd12);
      release_result("t4b");

      // Result held in DONE while the consumer stalls; a new request must be ignored.
      run_req("t5", 16'd5, 16'd3, 16'd23, 16'd12);
      in_valid = 1'b1;
      req_m = 16'd2; req_e = 16'd5; req_n = 16'd29; req_r2 = ref_r2(29);
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         check("t5_hold_valid", if_ct.out_valid, 1);
         check("t5_hold_out", if_ct.out, 10);
         check("t5_hold_in_ready", if_ct.in_ready, 0);
      end
      in_valid = 1'b0;
      release_result("t5");
      check("t5_out_kept", if_ct.out, 10);

      // Asynchronous reset in the middle of an operation.
      in_valid = 1'b1;
      req_m = 16'd5; req_e = 16'd3; req_n = 16'd23; req_r2 = 16'd12;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (199) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_out", longint'({if_ct.out, if_nc.out}), 0);
      check("t6_rst_flags", longint'({if_ct.err, if_ct.out_valid, if_ct.busy, if_ct.in_ready}),
            4'b0001);
      check("t6_rst_nc_flags",
            longint'({if_nc.err, if_nc.out_valid, if_nc.busy, if_nc.in_ready}), 4'b0001);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_req("t6", 16'd5, 16'd3, 16'd23, 16'd12);
      check("t6_out_const", if_ct.out, 10);
      release_result("t6");

      for (int j = 0; j < 80; j++) begin
         rn = W'($urandom_range(3, 65535)) | 16'd1;
         if (j % 16 == 15) rn = rn & ~16'd1;
         rm = (j % 20 == 19) ? rn : W'($urandom % rn);
         if (j % 8 == 0) re = '0;
         else if (j % 8 == 1) re = '1;
         else re = E_BITS'($urandom_range(0, 65535));
         run_req($sformatf("rnd%0d", j), rm, re, rn, ref_r2(rn));
         release_result($sformatf("rnd%0d", j));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
